fetch_buffer: RTL
=================

# fetch_buffer

Instruction prefetch queue between instruction memory and the ID stage of the riscv core. Generates sequential fetch addresses, captures each {pc, instr} pair into a DEPTH-entry FIFO, and presents entries to decode under a valid/ready handshake. A taken branch from EX flushes the queue and redirects fetch in one cycle. This decouples decode stalls from instruction memory.

## Interface

- DEPTH, 4: FIFO entries; power of two, 2..16.
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  taken-branch redirect (EX is_branched).
- redirect_pc  input  32  branch target; valid when flush=1.
- imem_pc  output  32  fetch address to instruction memory.
- imem_instr  input  32  instruction at imem_pc, combinational same cycle.
- out_valid  output  1  head entry valid for decode.
- out_instr  output  32  head entry instruction.
- out_pc  output  32  head entry pc.
- out_ready  input  1  decode accepts head this cycle.
- count  output  $clog2(DEPTH)+1  number of occupied entries.

## Operation

- State: fetch pointer fpc (drives imem_pc), storage mem[DEPTH] of 64-bit {pc, instr}, rd_ptr, wr_ptr ($clog2(DEPTH) bits, wrap modulo DEPTH), cnt.
- deq = out_valid & out_ready & ~flush.
- enq = ~flush & (cnt != DEPTH | deq): writes {imem_pc, imem_instr} at wr_ptr, wr_ptr+1, fpc <= fpc + 4 (32-bit wrap, 0xFFFFFFFC -> 0x00000000).
- deq: rd_ptr+1.
- cnt next = cnt + enq - deq; enq and deq both in one cycle at cnt=DEPTH is legal, cnt stays DEPTH.
- Full (cnt=DEPTH) without deq: no enq, fpc held, imem_pc stable.
- Empty: out_valid=0; out_instr/out_pc are don't-care, but are driven from mem[rd_ptr] (no X-gating required).
- flush: highest priority over enq/deq. Next cycle: cnt=0, rd_ptr=wr_ptr=0, fpc={redirect_pc[31:2], 2'b00}; the instruction presented on imem_instr in the flush cycle is discarded.
- reset: overrides flush. Next cycle: fpc=0, pointers 0, cnt=0.
- out_valid = (cnt != 0) in registered mode; out_instr/out_pc = mem[rd_ptr].
- count = cnt.
- No states beyond pointers and counter; no FSM required.

## Timing

- Reset values: imem_pc=0, out_valid=0, count=0; out_instr/out_pc don't-care.
- Fetch-to-decode latency: 1 cycle. A word fetched at cycle N is visible on out_* at N+1.
- Throughput: 1 instruction/cycle sustained while out_ready=1.
- Redirect: flush at cycle N -> imem_pc=target at N+1 -> out_valid=1 with target at N+2.
- out_valid does not depend combinationally on out_ready; out_* hold stable while out_valid=1 & out_ready=0.
- flush asserted with reset: reset wins.

## Configuration

- FETCH_BUFFER_BYPASS_EN: when defined and cnt=0 and ~flush, out_valid=1 combinationally with out_instr=imem_instr and out_pc=imem_pc (0-cycle latency). If out_ready=1 that cycle, the word is consumed without being written (fpc+4, cnt stays 0); otherwise it is enqueued normally. When undefined, the registered 1-cycle path described above applies and out_* never depend combinationally on imem_instr.

## Test plan

- Reset then out_ready=1, imem returns mem[pc]=pc^0xA5A5A5A5 -> imem_pc 0,4,8,...; out_pc 0 at cycle 1, then +4 each cycle; count stays 1.
- out_ready=0 for 10 cycles, DEPTH=4 -> count reaches 4, imem_pc holds 0x10, out_pc holds 0; on release, out_pc streams 0,4,8,0xC,0x10 with no gap.
- At full, assert out_ready for 1 cycle -> simultaneous enq/deq, count stays 4, imem_pc 0x10->0x14.
- flush with redirect_pc=0x203 while count=3 -> next cycle count=0, imem_pc=0x200, out_valid=0; following cycle out_pc=0x200.
- reset and flush together mid-stream -> imem_pc=0, count=0; a fetch at 0xFFFFFFFC (via redirect) wraps imem_pc to 0.
- With FETCH_BUFFER_BYPASS_EN, empty queue, out_ready=1 -> out_valid=1 same cycle as imem_pc=0, count remains 0.

Source files
------------

// File: rtl/fetch_buffer.sv
// Instruction prefetch queue: sequential fetch into a DEPTH-entry {pc, instr} FIFO with flush/redirect.
// Optional zero-latency empty-queue bypass enabled by defining FETCH_BUFFER_BYPASS_EN.
module fetch_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic [31:0]                redirect_pc,
    output logic [31:0]                imem_pc,
    input  logic [31:0]                imem_instr,
    output logic                       out_valid,
    output logic [31:0]                out_instr,
    output logic [31:0]                out_pc,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]    fpc;
    logic [63:0]    mem [DEPTH];
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;
    logic [CW-1:0]  cnt;

    logic           empty;
    logic           full;
    logic           deq;
    logic           enq;
    logic           write;
    logic [63:0]    head;

    assign empty = (cnt == '0);
    assign full  = (cnt == CW'(DEPTH));
    assign head  = mem[rd_ptr];

    // deq only ever pops a stored entry; a bypassed word is never in mem.
    assign deq = ~empty & out_ready & ~flush;
    assign enq = ~flush & (~full | deq);

`ifdef FETCH_BUFFER_BYPASS_EN
    logic bypass_hit;
    assign bypass_hit = empty & ~flush;
    assign write      = enq & ~(bypass_hit & out_ready);
    assign out_valid  = ~empty | bypass_hit;
    assign out_instr  = empty ? imem_instr : head[31:0];
    assign out_pc     = empty ? fpc : head[63:32];
`else
    assign write      = enq;
    assign out_valid  = ~empty;
    assign out_instr  = head[31:0];
    assign out_pc     = head[63:32];
`endif

    assign imem_pc = fpc;
    assign count   = cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            fpc    <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            fpc    <= {redirect_pc[31:2], 2'b00};
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (enq) begin
                fpc <= fpc + 32'd4;
            end
            if (write) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (deq) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            cnt <= cnt + CW'(write) - CW'(deq);
        end
    end

    // Storage needs no reset; contents are only observed when cnt says they are valid.
    always_ff @(posedge clk) begin
        if (write && !reset) begin
            mem[wr_ptr] <= {fpc, imem_instr};
        end
    end

endmodule
